// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce / edge-detect slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package debounce_pkg;

    // Debounce FSM encoding; the low bit marks the "checking a candidate change" states.
    typedef enum logic [1:0] {
        LOW_STABLE  = 2'b00,
        CHECK_HIGH  = 2'b01,
        HIGH_STABLE = 2'b10,
        CHECK_LOW   = 2'b11
    } state_t;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_EVT_W         = 8;

endpackage

// File: rtl/sat_event_counter.sv
// Saturating event counter with sticky overflow and synchronous clear.
// Latency: count/overflow update on the edge that samples inc/clr.
// Backpressure: none; every inc is absorbed (saturates rather than wraps).
module sat_event_counter
    import debounce_pkg::*;
#(
    parameter int EVT_W = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [EVT_W-1:0] count,
    output logic             overflow
);

    localparam logic [EVT_W-1:0] CNT_MAX = '1;

    // Clear wins but still counts a coincident event; at the top value the count holds and overflow latches.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= inc ? EVT_W'(1) : '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (count == CNT_MAX) begin
                overflow <= 1'b1;
            end else begin
                count <= count + EVT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debounce_edge_detect.sv
// Debounces a synchronized level, emits one-cycle rise/fall pulses and counts accepted rises.
// Latency: level_out changes on the STABLE_CYCLES-th edge sampling the new value; pulse follows for one cycle.
// Backpressure: none; input is sampled every cycle, all outputs registered.
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES),
    parameter int EVT_W         = DEF_EVT_W
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             sync_in,
    input  logic             clear_evt,
    output logic             level_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [EVT_W-1:0] evt_count,
    output logic             evt_overflow
);

    // A single-sample threshold would make the FSM degenerate (no check state needed).
    if (STABLE_CYCLES < 2) begin : g_bad_stable_cycles
        $fatal(1, "debounce_edge_detect: STABLE_CYCLES must be at least 2");
    end

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d;
    logic             rise_d;
    logic             fall_d;

    // Next-state: count consecutive samples that disagree with the accepted level; any agreeing sample aborts.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_out;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            LOW_STABLE: begin
                if (sync_in) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK_HIGH: begin
                if (!sync_in) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HIGH_STABLE: begin
                if (!sync_in) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_W'(1);
                end
            end
            CHECK_LOW: begin
                if (sync_in) begin
                    state_d = HIGH_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW_STABLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // State, stability count and all level/pulse outputs are registered together.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            state_q    <= LOW_STABLE;
            cnt_q      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_out  <= level_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

    // Rise acceptance feeds the counter on the same edge that raises level_out.
    sat_event_counter #(
        .EVT_W (EVT_W)
    ) u_evt_cnt (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .inc           (rise_d),
        .clr           (clear_evt),
        .count         (evt_count),
        .overflow      (evt_overflow)
    );

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Testbench for debounce_edge_detect: directed scenarios plus random runs against a sample-window model.
// Latency: n/a.
// Backpressure: n/a.
module tb_debounce_edge_detect;

    localparam int SC = 4;
    localparam int EW = 2;
    localparam int VW = EW + 4;

    logic          clk = 1'b0;
    logic          async_reset_n;
    logic          sync_in;
    logic          clear_evt;
    logic          level_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [EW-1:0] evt_count;
    logic          evt_overflow;

    int total = 0;
    int bad   = 0;

    // Reference model: accepted level, last SC samples since reset, pulse and counter state.
    logic          m_level;
    logic          m_rise;
    logic          m_fall;
    logic          m_ovf;
    logic [EW-1:0] m_cnt;
    logic          hist[$];

    logic [VW-1:0] obs;
    assign obs = {level_out, rise_pulse, fall_pulse, evt_overflow, evt_count};

    debounce_edge_detect #(
        .STABLE_CYCLES (SC),
        .EVT_W         (EW)
    ) dut (
        .clk           (clk),
        .async_reset_n (async_reset_n),
        .sync_in       (sync_in),
        .clear_evt     (clear_evt),
        .level_out     (level_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .evt_count     (evt_count),
        .evt_overflow  (evt_overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [VW-1:0] expv();
        return {m_level, m_rise, m_fall, m_ovf, m_cnt};
    endfunction

    task automatic model_reset();
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
        hist.delete();
    endtask

    // Drive one sample, let one rising edge pass, update the model, settle 1 time unit past the edge.
    task automatic tick(input logic s, input logic c);
        logic acc;
        sync_in   = s;
        clear_evt = c;
        @(posedge clk);
        hist.push_back(s);
        if (hist.size() > SC) void'(hist.pop_front());
        acc = 1'b0;
        if (hist.size() == SC) begin
            acc = 1'b1;
            foreach (hist[i]) if (hist[i] == m_level) acc = 1'b0;
        end
        m_rise = acc && !m_level;
        m_fall = acc && m_level;
        if (acc) m_level = !m_level;
        if (c) begin
            m_cnt = m_rise ? EW'(1) : '0;
            m_ovf = 1'b0;
        end else if (m_rise) begin
            if (m_cnt == {EW{1'b1}}) m_ovf = 1'b1;
            else m_cnt = m_cnt + EW'(1);
        end
        #1;
    endtask

    task automatic test_reset();
        async_reset_n = 1'b0;
        sync_in       = 1'b1;
        clear_evt     = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL reset_hold: got %b expected %b", obs, {VW{1'b0}});
            end
            sync_in = ~sync_in;
        end
        @(negedge clk);
        async_reset_n = 1'b1;
        tick(1'b0, 1'b0);
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL reset_release: got %b expected %b", obs, {VW{1'b0}});
        end
    endtask

    task automatic test_clean_rise();
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL clean_rise[%0d]: got %b expected %b", i, obs, expv());
            end
            if (i == 3) begin
                total++;
                if (level_out !== 1'b0) begin
                    bad++;
                    $display("FAIL clean_rise_early: got level %b expected 0", level_out);
                end
            end
            if (i == 4) begin
                total++;
                if ({level_out, rise_pulse, fall_pulse, evt_count} !== {3'b110, EW'(1)}) begin
                    bad++;
                    $display("FAIL clean_rise_accept: got lvl/rise/fall/cnt %b%b%b/%0d expected 110/1",
                             level_out, rise_pulse, fall_pulse, evt_count);
                end
            end
            if (i == 5) begin
                total++;
                if (rise_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL clean_rise_pulse_width: got rise %b expected 0", rise_pulse);
                end
            end
        end
    endtask

    task automatic test_clean_fall();
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL clean_fall[%0d]: got %b expected %b", i, obs, expv());
            end
            if (i == 4) begin
                total++;
                if ({level_out, rise_pulse, fall_pulse, evt_count} !== {3'b001, EW'(1)}) begin
                    bad++;
                    $display("FAIL clean_fall_accept: got lvl/rise/fall/cnt %b%b%b/%0d expected 001/1",
                             level_out, rise_pulse, fall_pulse, evt_count);
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int len = 1; len < SC; len++) begin
            for (int i = 0; i < len + 2; i++) begin
                tick(i < len, 1'b0);
                total++;
                if (obs !== expv() || obs !== {3'b000, 1'b0, EW'(1)}) begin
                    bad++;
                    $display("FAIL glitch_len%0d[%0d]: got %b expected %b", len, i, obs, {4'b0000, EW'(1)});
                end
            end
        end
    endtask

    task automatic do_rise_fall(input string tag);
        for (int i = 0; i < 2 * SC; i++) begin
            tick(i < SC, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL %s[%0d]: got %b expected %b", tag, i, obs, expv());
            end
        end
    endtask

    task automatic test_saturation();
        tick(1'b0, 1'b1);
        total++;
        if ({evt_overflow, evt_count} !== '0) begin
            bad++;
            $display("FAIL sat_preclear: got ovf/cnt %b/%0d expected 0/0", evt_overflow, evt_count);
        end
        for (int r = 1; r <= 4; r++) begin
            do_rise_fall("sat_rise");
            total++;
            if (evt_count !== EW'((r > 3) ? 3 : r) || evt_overflow !== (r == 4)) begin
                bad++;
                $display("FAIL sat_after_rise%0d: got ovf/cnt %b/%0d expected %b/%0d",
                         r, evt_overflow, evt_count, r == 4, (r > 3) ? 3 : r);
            end
        end
        tick(1'b0, 1'b1);
        total++;
        if ({evt_overflow, evt_count} !== '0 || obs !== expv()) begin
            bad++;
            $display("FAIL sat_clear: got ovf/cnt %b/%0d expected 0/0", evt_overflow, evt_count);
        end
        for (int r = 0; r < 4; r++) do_rise_fall("sat_refill");
        for (int i = 0; i < SC; i++) tick(1'b1, i == SC - 1);
        total++;
        if ({rise_pulse, evt_overflow, evt_count} !== {2'b10, EW'(1)} || obs !== expv()) begin
            bad++;
            $display("FAIL sat_clear_with_rise: got rise/ovf/cnt %b/%b/%0d expected 1/0/1",
                     rise_pulse, evt_overflow, evt_count);
        end
    endtask

    task automatic test_async_reset();
        tick(1'b1, 1'b0);
        #2;
        sync_in       = 1'b1;
        async_reset_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (obs !== '0) begin
            bad++;
            $display("FAIL async_reset_immediate: got %b expected %b", obs, {VW{1'b0}});
        end
        @(negedge clk);
        async_reset_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0);
            total++;
            if (obs !== '0) begin
                bad++;
                $display("FAIL async_reset_after: got %b expected %b", obs, {VW{1'b0}});
            end
        end
    endtask

    task automatic test_reset_mid_check();
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        #2;
        async_reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        sync_in       = 1'b1;
        async_reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1, 1'b0);
            total++;
            if (obs !== expv()) begin
                bad++;
                $display("FAIL mid_check[%0d]: got %b expected %b", i, obs, expv());
            end
            total++;
            if (level_out !== (i >= 4) || rise_pulse !== (i == 4)) begin
                bad++;
                $display("FAIL mid_check_timing[%0d]: got lvl/rise %b/%b expected %b/%b",
                         i, level_out, rise_pulse, i >= 4, i == 4);
            end
        end
    endtask

    task automatic test_random();
        logic v;
        int   run;
        int   n;
        v = 1'b0;
        n = 0;
        while (n < 1500) begin
            v   = ~v;
            run = $urandom_range(1, SC + 2);
            for (int i = 0; i < run; i++) begin
                tick(v, ($urandom_range(0, 15) == 0));
                n++;
                total++;
                if (obs !== expv()) begin
                    bad++;
                    $display("FAIL random[%0d]: got %b expected %b", n, obs, expv());
                end
                total++;
                if (rise_pulse === 1'b1 && fall_pulse === 1'b1) begin
                    bad++;
                    $display("FAIL random_both_pulses[%0d]: got rise=1 fall=1 expected at most one", n);
                end
            end
            if (n % 500 < run) begin
                #2;
                async_reset_n = 1'b0;
                model_reset();
                @(negedge clk);
                async_reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_clean_fall();
        test_glitch();
        test_saturation();
        test_async_reset();
        test_reset_mid_check();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
